// File: rtl/bus_arb_if.sv
// Signal bundle between the two bus masters, the arbiter and the shared BUS port.
// The arbiter connects through the slave modport; a master-side agent connects through master.
interface bus_arb_if;
   logic        m0_req;
   logic        m1_req;
   logic        m0_wr;
   logic        m1_wr;
   logic [15:0] m0_addr;
   logic [15:0] m1_addr;
   logic [63:0] m0_dout;
   logic [63:0] m1_dout;
   logic        m0_grant;
   logic        m1_grant;
   logic [63:0] m0_din;
   logic [63:0] m1_din;
   logic        bus_req;
   logic        bus_wr;
   logic [15:0] bus_addr;
   logic [63:0] bus_dout;
   logic [63:0] bus_din;

   modport slave (
      input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout, bus_din,
      output m0_grant, m1_grant, m0_din, m1_din, bus_req, bus_wr, bus_addr, bus_dout
   );

   modport master (
      output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_dout, m1_dout, bus_din,
      input  m0_grant, m1_grant, m0_din, m1_din, bus_req, bus_wr, bus_addr, bus_dout
   );
endinterface

// File: rtl/bus_arb.sv
// Two-master round-robin bus arbiter with a burst limit of MAX_BURST cycles under contention.
// Grants come straight from the state register; the bus mux follows the current owner.
module bus_arb #(
   parameter int MAX_BURST = 4
) (
   input logic       clk,
   input logic       reset,
   bus_arb_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

   state_t      state;
   state_t      next_state;
   logic [3:0]  cnt;
   logic [3:0]  next_cnt;
   logic        last;
   logic        next_last;
   logic        own_req;
   logic        oth_req;

   // last resets to 1 so master 0 wins the very first tie
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         last  <= 1'b1;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         last  <= next_last;
      end
   end

   // The counter advances every cycle the owner keeps the bus (saturating), so a long
   // solo owner hands over quickly once the other master finally asks.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_last  = last;
      own_req    = 1'b0;
      oth_req    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.m0_req && bus.m1_req)
               next_state = last ? GNT0 : GNT1;
            else if (bus.m0_req)
               next_state = GNT0;
            else if (bus.m1_req)
               next_state = GNT1;
         end
         GNT0, GNT1: begin
            own_req = (state == GNT0) ? bus.m0_req : bus.m1_req;
            oth_req = (state == GNT0) ? bus.m1_req : bus.m0_req;
            if (own_req && !oth_req)
               next_cnt = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
            else if (own_req && oth_req && cnt != CNT_MAX)
               next_cnt = cnt + 4'd1;
            else if (oth_req)
               next_state = (state == GNT0) ? GNT1 : GNT0;
            else
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase

      if (next_state != state && next_state != IDLE) begin
         next_cnt  = 4'd0;
         next_last = (next_state == GNT1);
      end else if (next_state == IDLE) begin
         next_cnt  = 4'd0;
      end
   end

   assign bus.m0_grant = (state == GNT0);
   assign bus.m1_grant = (state == GNT1);
   assign bus.m0_din   = bus.bus_din;
   assign bus.m1_din   = bus.bus_din;

   // bus_req follows the owner's live request, so a dropped request leaves the bus at once
   always_comb begin
      bus.bus_req  = 1'b0;
      bus.bus_wr   = 1'b0;
      bus.bus_addr = 16'd0;
      bus.bus_dout = 64'd0;
      case (state)
         GNT0: begin
            bus.bus_req  = bus.m0_req;
            bus.bus_wr   = bus.m0_wr;
            bus.bus_addr = bus.m0_addr;
            bus.bus_dout = bus.m0_dout;
         end
         GNT1: begin
            bus.bus_req  = bus.m1_req;
            bus.bus_wr   = bus.m1_wr;
            bus.bus_addr = bus.m1_addr;
            bus.bus_dout = bus.m1_dout;
         end
         default: ;
      endcase
   end

endmodule
